bcd_stopwatch: RTL and testbench
================================

# bcd_stopwatch

Parametrised multi-digit BCD stopwatch/timer core for the clock design: counts up or down in decimal on a 1 Hz tick enable, with run/stop control, preset load, lap hold and selectable wrap or saturate-and-stop at the terminal value. It runs on the system clock, takes the divider's tick as an enable, and drives the seven-segment scan logic through `disp`.

## Interface
- `DIGITS`, 4: number of BCD digits; the vector width is 4*DIGITS, with digit 0 in bits [3:0] as the least significant.
- `WRAP`, 1: 1 = wrap at the terminal value and keep running; 0 = saturate at the terminal value and stop.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle count enable from the clock divider (1 Hz).
- `start_stop`  in  1  one-cycle pulse; toggles between STOPPED and RUNNING.
- `clear`  in  1  synchronous clear, level-sensitive.
- `load`  in  1  one-cycle pulse; loads `load_val` into the count.
- `load_val`  in  4*DIGITS  preset value in BCD.
- `dir`  in  1  0 = count up, 1 = count down.
- `lap`  in  1  one-cycle pulse; toggles the lap hold.
- `count`  out  4*DIGITS  live count in BCD (registered).
- `disp`  out  4*DIGITS  display value: `lap_reg` when `lap_active` is 1, otherwise `count` (combinational mux of registers).
- `running`  out  1  1 when the state is RUNNING.
- `lap_active`  out  1  lap hold engaged.
- `term`  out  1  one-cycle pulse on reaching or passing the terminal value.
- `at_zero`  out  1  1 when `count` is all zeros.

## Operation
- Two states, STOPPED and RUNNING. Reset state is STOPPED.
  - STOPPED -> RUNNING on `start_stop`.
  - RUNNING -> STOPPED on `start_stop`, on `clear`, or on saturation when `WRAP` is 0.
- Per-cycle priority: `clear` > `load` > count advance.
  - Count advance happens only when `tick` is 1 and the state is RUNNING.
- `clear`:
  - `count` goes to 0.
  - `lap_active` goes to 0 and `lap_reg` goes to 0.
  - The state goes to STOPPED.
  - `term` is not asserted.
- `load`:
  - Sets `count` to `load_val`, with each digit above 9 clamped to 9.
  - State and lap hold are unchanged.
  - A `tick` in the same cycle is ignored.
- Up count: BCD ripple increment. Each digit goes 9 -> 0 with a carry into the next digit.
  - At the terminal value (all 9s), `WRAP`=1: `count` becomes all 0s and `term` pulses.
  - At the terminal value, `WRAP`=0: `count` holds at all 9s, `term` pulses, and the state goes to STOPPED.
- Down count: BCD ripple decrement. Each digit goes 0 -> 9 with a borrow from the next digit.
  - At the terminal value (all 0s), `WRAP`=1: `count` becomes all 9s and `term` pulses.
  - At the terminal value, `WRAP`=0: `count` holds at 0, `term` pulses, and the state goes to STOPPED.
  - With `WRAP`=0, reaching 0 from 1 also pulses `term` and stops (countdown-timer completion).
- `dir` is sampled on each advancing tick. Changing it mid-run takes effect on the next tick.
- `lap`:
  - When `lap_active` is 0: `lap_reg` captures the pre-update `count` of that cycle and `lap_active` goes to 1.
  - When `lap_active` is 1: `lap_active` goes to 0.
  - Accepted in either state. `count` continues to advance underneath the hold.
- `start_stop` and `tick` in the same cycle: the tick is qualified by the pre-toggle state.
  - Starting a stopped counter does not advance it on that tick.
  - Stopping a running counter does advance it on that tick.
- With `WRAP`=0 and `count` already at the terminal value for the current `dir`, `start_stop` still enters RUNNING. The next tick pulses `term` again and stops.

## Timing
- All state is updated on the rising edge of `clk`; `rst_n` low clears everything immediately.
- Reset values:
  - `count` = 0, `lap_reg` = 0, `disp` = 0.
  - `running` = 0, `lap_active` = 0, `term` = 0, `at_zero` = 1.
- Latency from input to output:
  - A `tick` sampled at edge N gives the new `count` after edge N, and `term` high for exactly the cycle after edge N.
  - `disp` follows `count` in the same cycle when not held.
  - `at_zero` is decoded from registered `count`, so it is valid in the same cycle as `count`.
- Reset deasserted mid-count: the block restarts from STOPPED/0. No tick is lost or duplicated after release; the first counted tick is the first one seen in RUNNING.
- Pulse inputs are assumed to be one cycle wide and synchronous to `clk`. A held pulse input is acted on once per cycle.

## Test plan
- Reset, `start_stop`, then 10 ticks up (DIGITS=4) -> `count` = 0010 and `running` = 1; after 2 more ticks, `count` = 0012.
- `load` 9998, `WRAP`=1, run up for 2 ticks -> 9999 then 0000, with `term` high for one cycle on the second tick.
- `WRAP`=0, `load` 0003, `dir`=1, run for 4 ticks:
  - `count` goes 0002, 0001, 0000.
  - `term` pulses on the 0000 tick and `running` drops to 0.
  - The 4th tick leaves `count` at 0000.
- Running at 0041, pulse `lap`, then 5 ticks:
  - `disp` = 0041 while `count` = 0046.
  - A second `lap` pulse -> `disp` = 0046.
- Same-cycle conflicts:
  - `clear`+`load`+`tick` -> `count` = 0, STOPPED.
  - `load` 1234 + `tick` while running -> `count` = 1234.
  - `load_val` with digits above 9 (e.g. F07A) -> `count` = 9079.
- `start_stop` coincident with `tick`:
  - From STOPPED: no advance and `running` = 1.
  - From RUNNING: advance by one and `running` = 0.
  - `rst_n` pulsed low mid-run -> all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/bcd_stopwatch.sv
// rtl/bcd_stopwatch.sv - multi-digit BCD stopwatch/timer with run/stop, preset load, lap hold and wrap/saturate
module bcd_stopwatch #(
    parameter int DIGITS = 4,
    parameter bit WRAP   = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                start_stop,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                dir,
    input  logic                lap,
    output logic [4*DIGITS-1:0] count,
    output logic [4*DIGITS-1:0] disp,
    output logic                running,
    output logic                lap_active,
    output logic                term,
    output logic                at_zero
);
    localparam int W = 4 * DIGITS;

    typedef enum logic {STOPPED = 1'b0, RUNNING = 1'b1} state_t;

    state_t         state_q;
    logic [W-1:0]   count_q, count_d;
    logic [W-1:0]   lap_q;
    logic           lap_active_q;
    logic           term_q, term_d;
    logic           sat_stop;

    logic [W-1:0]   count_inc, count_dec, load_clamped;
    logic           all_nines, all_zero, dec_zero;
    logic           carry, borrow;

    // Ripple BCD increment/decrement of the live count and per-digit clamp of the preset
    always_comb begin
        count_inc    = count_q;
        count_dec    = count_q;
        load_clamped = load_val;
        all_nines    = 1'b1;
        carry        = 1'b1;
        borrow       = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
            if (carry) begin
                if (count_q[4*i +: 4] >= 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_val[4*i +: 4] > 4'd9) load_clamped[4*i +: 4] = 4'd9;
        end
    end

    assign all_zero = (count_q == '0);
    assign dec_zero = (count_dec == '0);

    // Next count and terminal pulse; priority clear > load > advance, advance qualified by pre-toggle state
    always_comb begin
        count_d  = count_q;
        term_d   = 1'b0;
        sat_stop = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (tick && state_q == RUNNING) begin
            if (!dir) begin
                if (all_nines) begin
                    term_d = 1'b1;
                    if (WRAP) count_d = '0;
                    else      sat_stop = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end else begin
                if (all_zero) begin
                    term_d = 1'b1;
                    if (WRAP) count_d = count_dec;
                    else      sat_stop = 1'b1;
                end else begin
                    count_d = count_dec;
                    if (!WRAP && dec_zero) begin
                        term_d   = 1'b1;
                        sat_stop = 1'b1;
                    end
                end
            end
        end
    end

    // Run/stop state machine; a held terminal value can still be re-entered with start_stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STOPPED;
        end else if (clear) begin
            state_q <= STOPPED;
        end else begin
            case (state_q)
                STOPPED: if (start_stop)             state_q <= RUNNING;
                RUNNING: if (start_stop || sat_stop) state_q <= STOPPED;
                default:                             state_q <= STOPPED;
            endcase
        end
    end

    // Count and terminal pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            term_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            term_q  <= term_d;
        end
    end

    // Lap hold: first pulse freezes the pre-update count, second pulse releases it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q        <= '0;
            lap_active_q <= 1'b0;
        end else if (clear) begin
            lap_q        <= '0;
            lap_active_q <= 1'b0;
        end else if (lap) begin
            if (lap_active_q) begin
                lap_active_q <= 1'b0;
            end else begin
                lap_q        <= count_q;
                lap_active_q <= 1'b1;
            end
        end
    end

    assign count      = count_q;
    assign disp       = lap_active_q ? lap_q : count_q;
    assign running    = (state_q == RUNNING);
    assign lap_active = lap_active_q;
    assign term       = term_q;
    assign at_zero    = all_zero;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb/tb_bcd_stopwatch.sv - directed self-checking bench for bcd_stopwatch (wrap and saturate instances)
module tb_bcd_stopwatch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0, start_stop = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0, lap = 1'b0;
    logic [15:0] load_val = 16'h0000;

    logic [15:0] count_w, disp_w, count_s, disp_s;
    logic        running_w, lap_w, term_w, zero_w;
    logic        running_s, lap_s, term_s, zero_s;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_stopwatch #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear),
        .load(load), .load_val(load_val), .dir(dir), .lap(lap),
        .count(count_w), .disp(disp_w), .running(running_w), .lap_active(lap_w),
        .term(term_w), .at_zero(zero_w)
    );

    bcd_stopwatch #(.DIGITS(4), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start_stop(start_stop), .clear(clear),
        .load(load), .load_val(load_val), .dir(dir), .lap(lap),
        .count(count_s), .disp(disp_s), .running(running_s), .lap_active(lap_s),
        .term(term_s), .at_zero(zero_s)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
        start_stop = 1'b0; load = 1'b0; lap = 1'b0; tick = 1'b0; clear = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cycle();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (count_w !== 16'h0000) begin n_fail++; $display("FAIL rst_count got %h exp 0000", count_w); end
        n_cmp++; if (disp_w !== 16'h0000) begin n_fail++; $display("FAIL rst_disp got %h exp 0000", disp_w); end
        n_cmp++; if (running_w !== 1'b0) begin n_fail++; $display("FAIL rst_running got %b exp 0", running_w); end
        n_cmp++; if (lap_w !== 1'b0) begin n_fail++; $display("FAIL rst_lap got %b exp 0", lap_w); end
        n_cmp++; if (term_w !== 1'b0) begin n_fail++; $display("FAIL rst_term got %b exp 0", term_w); end
        n_cmp++; if (zero_w !== 1'b1) begin n_fail++; $display("FAIL rst_at_zero got %b exp 1", zero_w); end
        n_cmp++; if (count_s !== 16'h0000 || running_s !== 1'b0) begin n_fail++; $display("FAIL rst_sat got %h/%b exp 0000/0", count_s, running_s); end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_count_up();
        dir = 1'b0;
        start_stop = 1'b1;
        cycle();
        n_cmp++; if (running_w !== 1'b1 || count_w !== 16'h0000) begin n_fail++; $display("FAIL start_state got %b/%h exp 1/0000", running_w, count_w); end
        tick_n(10);
        n_cmp++; if (count_w !== 16'h0010) begin n_fail++; $display("FAIL up10_count got %h exp 0010", count_w); end
        n_cmp++; if (running_w !== 1'b1) begin n_fail++; $display("FAIL up10_running got %b exp 1", running_w); end
        n_cmp++; if (zero_w !== 1'b0) begin n_fail++; $display("FAIL up10_at_zero got %b exp 0", zero_w); end
        tick_n(2);
        n_cmp++; if (count_w !== 16'h0012) begin n_fail++; $display("FAIL up12_count got %h exp 0012", count_w); end
        n_cmp++; if (disp_w !== 16'h0012) begin n_fail++; $display("FAIL up12_disp got %h exp 0012", disp_w); end
    endtask

    task automatic test_wrap_up();
        load_val = 16'h9998;
        load = 1'b1;
        cycle();
        n_cmp++; if (count_w !== 16'h9998 || count_s !== 16'h9998) begin n_fail++; $display("FAIL load9998 got %h/%h exp 9998", count_w, count_s); end
        tick_n(1);
        n_cmp++; if (count_w !== 16'h9999 || term_w !== 1'b0) begin n_fail++; $display("FAIL wrap_t1 got %h/%b exp 9999/0", count_w, term_w); end
        n_cmp++; if (term_s !== 1'b0) begin n_fail++; $display("FAIL sat_t1_term got %b exp 0", term_s); end
        tick_n(1);
        n_cmp++; if (count_w !== 16'h0000 || term_w !== 1'b1) begin n_fail++; $display("FAIL wrap_t2 got %h/%b exp 0000/1", count_w, term_w); end
        n_cmp++; if (running_w !== 1'b1) begin n_fail++; $display("FAIL wrap_t2_running got %b exp 1", running_w); end
        n_cmp++; if (count_s !== 16'h9999 || term_s !== 1'b1 || running_s !== 1'b0) begin n_fail++; $display("FAIL sat_t2 got %h/%b/%b exp 9999/1/0", count_s, term_s, running_s); end
        cycle();
        n_cmp++; if (term_w !== 1'b0 || term_s !== 1'b0) begin n_fail++; $display("FAIL term_width got %b/%b exp 0/0", term_w, term_s); end
    endtask

    task automatic test_countdown();
        clear = 1'b1;
        cycle();
        n_cmp++; if (running_w !== 1'b0 || count_w !== 16'h0000) begin n_fail++; $display("FAIL clear got %b/%h exp 0/0000", running_w, count_w); end
        load_val = 16'h0003;
        load = 1'b1;
        dir = 1'b1;
        cycle();
        start_stop = 1'b1;
        cycle();
        tick_n(1);
        n_cmp++; if (count_s !== 16'h0002) begin n_fail++; $display("FAIL down_t1 got %h exp 0002", count_s); end
        tick_n(1);
        n_cmp++; if (count_s !== 16'h0001 || term_s !== 1'b0) begin n_fail++; $display("FAIL down_t2 got %h/%b exp 0001/0", count_s, term_s); end
        tick_n(1);
        n_cmp++; if (count_s !== 16'h0000 || term_s !== 1'b1 || running_s !== 1'b0) begin n_fail++; $display("FAIL down_t3_sat got %h/%b/%b exp 0000/1/0", count_s, term_s, running_s); end
        n_cmp++; if (count_w !== 16'h0000 || term_w !== 1'b0 || running_w !== 1'b1) begin n_fail++; $display("FAIL down_t3_wrap got %h/%b/%b exp 0000/0/1", count_w, term_w, running_w); end
        tick_n(1);
        n_cmp++; if (count_s !== 16'h0000 || term_s !== 1'b0) begin n_fail++; $display("FAIL down_t4_sat got %h/%b exp 0000/0", count_s, term_s); end
        n_cmp++; if (count_w !== 16'h9999 || term_w !== 1'b1) begin n_fail++; $display("FAIL down_t4_wrap got %h/%b exp 9999/1", count_w, term_w); end
        start_stop = 1'b1;
        cycle();
        n_cmp++; if (running_s !== 1'b1) begin n_fail++; $display("FAIL sat_restart got %b exp 1", running_s); end
        tick_n(1);
        n_cmp++; if (count_s !== 16'h0000 || term_s !== 1'b1 || running_s !== 1'b0) begin n_fail++; $display("FAIL sat_reterm got %h/%b/%b exp 0000/1/0", count_s, term_s, running_s); end
        dir = 1'b0;
    endtask

    task automatic test_lap();
        clear = 1'b1;
        cycle();
        load_val = 16'h0041;
        load = 1'b1;
        cycle();
        start_stop = 1'b1;
        cycle();
        lap = 1'b1;
        cycle();
        n_cmp++; if (lap_w !== 1'b1 || disp_w !== 16'h0041) begin n_fail++; $display("FAIL lap_on got %b/%h exp 1/0041", lap_w, disp_w); end
        tick_n(5);
        n_cmp++; if (count_w !== 16'h0046 || disp_w !== 16'h0041) begin n_fail++; $display("FAIL lap_hold got %h/%h exp 0046/0041", count_w, disp_w); end
        lap = 1'b1;
        cycle();
        n_cmp++; if (lap_w !== 1'b0 || disp_w !== 16'h0046) begin n_fail++; $display("FAIL lap_off got %b/%h exp 0/0046", lap_w, disp_w); end
    endtask

    task automatic test_conflicts();
        clear = 1'b1; load = 1'b1; tick = 1'b1; load_val = 16'h5555;
        cycle();
        n_cmp++; if (count_w !== 16'h0000 || running_w !== 1'b0 || term_w !== 1'b0) begin n_fail++; $display("FAIL clr_ld_tk got %h/%b/%b exp 0000/0/0", count_w, running_w, term_w); end
        start_stop = 1'b1;
        cycle();
        load = 1'b1; tick = 1'b1; load_val = 16'h1234;
        cycle();
        n_cmp++; if (count_w !== 16'h1234 || running_w !== 1'b1) begin n_fail++; $display("FAIL ld_tk got %h/%b exp 1234/1", count_w, running_w); end
        load = 1'b1; load_val = 16'hF07A;
        cycle();
        n_cmp++; if (count_w !== 16'h9079) begin n_fail++; $display("FAIL ld_clamp got %h exp 9079", count_w); end
    endtask

    task automatic test_start_tick();
        clear = 1'b1;
        cycle();
        start_stop = 1'b1; tick = 1'b1;
        cycle();
        n_cmp++; if (count_w !== 16'h0000 || running_w !== 1'b1) begin n_fail++; $display("FAIL ss_tk_start got %h/%b exp 0000/1", count_w, running_w); end
        tick_n(1);
        n_cmp++; if (count_w !== 16'h0001) begin n_fail++; $display("FAIL ss_first_tick got %h exp 0001", count_w); end
        start_stop = 1'b1; tick = 1'b1;
        cycle();
        n_cmp++; if (count_w !== 16'h0002 || running_w !== 1'b0) begin n_fail++; $display("FAIL ss_tk_stop got %h/%b exp 0002/0", count_w, running_w); end
        tick_n(2);
        n_cmp++; if (count_w !== 16'h0002) begin n_fail++; $display("FAIL stopped_hold got %h exp 0002", count_w); end
    endtask

    task automatic test_reset_mid();
        start_stop = 1'b1;
        cycle();
        tick_n(3);
        lap = 1'b1;
        cycle();
        n_cmp++; if (count_w !== 16'h0005 || lap_w !== 1'b1) begin n_fail++; $display("FAIL pre_rst got %h/%b exp 0005/1", count_w, lap_w); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (count_w !== 16'h0000 || disp_w !== 16'h0000) begin n_fail++; $display("FAIL arst_count got %h/%h exp 0000/0000", count_w, disp_w); end
        n_cmp++; if (running_w !== 1'b0 || lap_w !== 1'b0 || term_w !== 1'b0 || zero_w !== 1'b1) begin n_fail++; $display("FAIL arst_flags got r%b l%b t%b z%b exp r0 l0 t0 z1", running_w, lap_w, term_w, zero_w); end
        tick = 1'b1;
        cycle();
        rst_n = 1'b1;
        tick_n(2);
        n_cmp++; if (count_w !== 16'h0000 || running_w !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got %h/%b exp 0000/0", count_w, running_w); end
        start_stop = 1'b1;
        cycle();
        tick_n(1);
        n_cmp++; if (count_w !== 16'h0001) begin n_fail++; $display("FAIL post_rst_tick got %h exp 0001", count_w); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_countdown();
        test_lap();
        test_conflicts();
        test_start_tick();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
